// File: rtl/stdp_weight_updater_if.sv
// Spike strobes, STDP coefficients and weight/age status between a neuron pair and its synapse.
`timescale 1ns/1ps
interface stdp_weight_updater_if #(
  parameter int N = 32,
  parameter int T = 16
);
  logic                apply;
  logic                pre_spike;
  logic                post_spike;
  logic                load;
  logic signed [N-1:0] weight_init;
  logic signed [N-1:0] m1;
  logic signed [N-1:0] b1;
  logic signed [N-1:0] m2;
  logic signed [N-1:0] b2;
  logic [T-1:0]        window;
  logic signed [N-1:0] weight;
  logic                busy;
  logic                update_valid;
  logic [T-1:0]        pre_age;
  logic [T-1:0]        post_age;

  modport master (
    output apply, pre_spike, post_spike, load, weight_init, m1, b1, m2, b2, window,
    input  weight, busy, update_valid, pre_age, post_age
  );

  modport slave (
    input  apply, pre_spike, post_spike, load, weight_init, m1, b1, m2, b2, window,
    output weight, busy, update_valid, pre_age, post_age
  );
endinterface

// File: rtl/stdp_weight_updater.sv
// Pair-based STDP for one synapse: dw = m*dt + b, clamped write-back; update_valid 3 cycles after accept (4 with STDP_SOFT_BOUND_EN).
// No backpressure: apply/load are only taken in IDLE and silently dropped while busy.
`timescale 1ns/1ps
module stdp_weight_updater #(
  parameter int                  N     = 32,
  parameter int                  Q     = 16,
  parameter int                  T     = 16,
  parameter logic signed [N-1:0] W_MAX = 32'h0001_0000,
  parameter logic signed [N-1:0] W_MIN = 32'h0000_0000
) (
  input logic                  clk,
  input logic                  rst,
  stdp_weight_updater_if.slave bus
);
  typedef enum logic [2:0] {IDLE, MUL, ADD, SCALE, WRITE} state_t;

  localparam int PW = N + T + 2;
  localparam logic signed [N-1:0] S_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] S_MIN = {1'b1, {(N-1){1'b0}}};

  state_t              state, state_nxt;
  logic [T-1:0]        pre_age, post_age;
  logic                pre_valid, post_valid, is_pot, update_valid;
  logic [T:0]          dt;
  logic signed [N-1:0] weight, m_r, b_r, prod, dw;

  function automatic logic [T-1:0] age_inc(input logic [T-1:0] a);
    return (a == '1) ? a : a + T'(1);
  endfunction

  // Pair qualification uses the ages as they stood before this timestep.
  logic [T:0] pot_dt, dep_dt;
  logic       pot_hit, dep_hit;
  assign pot_dt  = {1'b0, pre_age} + (T+1)'(1);
  assign dep_dt  = {1'b0, post_age} + (T+1)'(1);
  assign pot_hit = bus.post_spike && !bus.pre_spike && pre_valid && (pot_dt <= {1'b0, bus.window});
  assign dep_hit = bus.pre_spike && !bus.post_spike && post_valid && (dep_dt <= {1'b0, bus.window});

  logic signed [PW-1:0] prod_full;
  logic                 prod_fits;
  logic signed [N:0]    add_full;
  assign prod_full = PW'(m_r) * PW'($signed({1'b0, dt}));
  assign prod_fits = (prod_full[PW-1:N-1] == {(PW-N+1){prod_full[N-1]}});
  assign add_full  = {prod[N-1], prod} + {b_r[N-1], b_r};

  logic signed [N:0]   w_ext, dw_ext, w_pot, w_dep;
  logic signed [N-1:0] w_next;
  assign w_ext  = {weight[N-1], weight};
  assign dw_ext = {dw[N-1], dw};
  assign w_pot  = w_ext + dw_ext;
  assign w_dep  = w_ext - dw_ext;

  always_comb begin
    w_next = weight;
    if (!dw[N-1] && (dw != '0)) begin
      if (is_pot) w_next = (w_pot > $signed({W_MAX[N-1], W_MAX})) ? W_MAX : w_pot[N-1:0];
      else        w_next = (w_dep < $signed({W_MIN[N-1], W_MIN})) ? W_MIN : w_dep[N-1:0];
    end
  end

`ifdef STDP_SOFT_BOUND_EN
  // Soft bound: shrink dw by the remaining headroom toward the bound being approached.
  logic signed [N:0]     span;
  logic signed [2*N:0]   scale_full, scale_sh;
  logic signed [N-1:0]   dw_scaled;
  assign span       = is_pot ? ($signed({W_MAX[N-1], W_MAX}) - w_ext)
                             : (w_ext - $signed({W_MIN[N-1], W_MIN}));
  assign scale_full = (2*N+1)'(dw) * (2*N+1)'(span);
  assign scale_sh   = scale_full >>> Q;
  assign dw_scaled  = (scale_sh[2*N:N-1] == {(N+2){scale_sh[N-1]}}) ? scale_sh[N-1:0]
                    : (scale_sh[2*N] ? S_MIN : S_MAX);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.apply && !bus.load && (pot_hit || dep_hit)) state_nxt = MUL;
      MUL:     state_nxt = ADD;
`ifdef STDP_SOFT_BOUND_EN
      ADD:     state_nxt = SCALE;
`else
      ADD:     state_nxt = WRITE;
`endif
      SCALE:   state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_age      <= '0;
      post_age     <= '0;
      pre_valid    <= 1'b0;
      post_valid   <= 1'b0;
      is_pot       <= 1'b0;
      dt           <= '0;
      m_r          <= '0;
      b_r          <= '0;
      prod         <= '0;
      dw           <= '0;
      weight       <= '0;
      update_valid <= 1'b0;
    end else begin
      update_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load) begin
            weight     <= bus.weight_init;
            pre_age    <= '0;
            post_age   <= '0;
            pre_valid  <= 1'b0;
            post_valid <= 1'b0;
          end else if (bus.apply) begin
            pre_age    <= bus.pre_spike  ? '0 : age_inc(pre_age);
            post_age   <= bus.post_spike ? '0 : age_inc(post_age);
            pre_valid  <= pre_valid  | bus.pre_spike;
            post_valid <= post_valid | bus.post_spike;
            is_pot     <= pot_hit;
            dt         <= pot_hit ? pot_dt : dep_dt;
            m_r        <= pot_hit ? bus.m1 : bus.m2;
            b_r        <= pot_hit ? bus.b1 : bus.b2;
          end
        end
        MUL: prod <= prod_fits ? prod_full[N-1:0] : (prod_full[PW-1] ? S_MIN : S_MAX);
        ADD: dw   <= (add_full[N] == add_full[N-1]) ? add_full[N-1:0] : (add_full[N] ? S_MIN : S_MAX);
`ifdef STDP_SOFT_BOUND_EN
        SCALE: dw <= dw_scaled;
`endif
        WRITE: begin
          weight       <= w_next;
          update_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.weight       = weight;
  assign bus.busy         = (state != IDLE);
  assign bus.update_valid = update_valid;
  assign bus.pre_age      = pre_age;
  assign bus.post_age     = post_age;
endmodule

// File: tb/tb_stdp_weight_updater.sv
// Directed plus randomized STDP timesteps compared against an arithmetic model of the pairing rules.
`timescale 1ns/1ps
module tb_stdp_weight_updater;
  localparam longint WMAX = 64'h1_0000;
  localparam longint WMIN = 0;
`ifdef STDP_SOFT_BOUND_EN
  localparam int LAT  = 4;
  localparam bit SOFT = 1'b1;
`else
  localparam int LAT  = 3;
  localparam bit SOFT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stdp_weight_updater_if #(.N(32), .T(16)) bus ();
  stdp_weight_updater dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  longint mw, mpre_age, mpost_age;
  bit     mpre_v, mpost_v;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint sat32(input longint v);
    if (v > 64'sh7FFF_FFFF) return 64'sh7FFF_FFFF;
    if (v < -64'sh8000_0000) return -64'sh8000_0000;
    return v;
  endfunction

  function automatic longint next_weight(input longint w, input bit pot, input longint dt,
                                         input longint m, input longint b);
    longint dw;
    dw = sat32(sat32(m * dt) + b);
    if (SOFT) dw = sat32((dw * (pot ? WMAX - w : w - WMIN)) >>> 16);
    if (dw <= 0) return w;
    if (pot) return (w + dw > WMAX) ? WMAX : w + dw;
    return (w - dw < WMIN) ? WMIN : w - dw;
  endfunction

  function automatic longint age_step(input longint age, input bit spiked);
    if (spiked) return 0;
    return (age >= 65535) ? 65535 : age + 1;
  endfunction

  task automatic model_reset();
    mw = 0; mpre_age = 0; mpost_age = 0; mpre_v = 1'b0; mpost_v = 1'b0;
  endtask

  // A simultaneous apply with spikes must be ignored in favour of load.
  task automatic do_load(input longint w);
    bus.load = 1'b1; bus.weight_init = w[31:0];
    bus.apply = 1'b1; bus.pre_spike = 1'b1; bus.post_spike = 1'b0;
    @(posedge clk); #1;
    bus.load = 1'b0; bus.apply = 1'b0; bus.pre_spike = 1'b0;
    model_reset();
    mw = w;
    check("load_weight", $signed(bus.weight), mw);
    check("load_pre_age", bus.pre_age, mpre_age);
    check("load_busy", bus.busy, 0);
    @(negedge clk);
  endtask

  // hammer keeps apply asserted with a pre spike for the whole busy period.
  task automatic step(input bit pre, input bit post, input bit hammer);
    bit     upd, pot;
    longint dt, exp_w;
    int     k;
    upd = 1'b0; pot = 1'b0; dt = 0;
    if (post && !pre && mpre_v) begin
      pot = 1'b1; dt = mpre_age + 1; upd = (dt <= longint'(bus.window));
    end else if (pre && !post && mpost_v) begin
      dt = mpost_age + 1; upd = (dt <= longint'(bus.window));
    end
    exp_w = upd ? next_weight(mw, pot, dt,
                              pot ? longint'($signed(bus.m1)) : longint'($signed(bus.m2)),
                              pot ? longint'($signed(bus.b1)) : longint'($signed(bus.b2))) : mw;
    mpre_age  = age_step(mpre_age, pre);
    mpost_age = age_step(mpost_age, post);
    mpre_v    = mpre_v | pre;
    mpost_v   = mpost_v | post;

    bus.apply = 1'b1; bus.pre_spike = pre; bus.post_spike = post;
    @(posedge clk); #1;
    if (hammer) begin
      bus.pre_spike = 1'b1; bus.post_spike = 1'b0;
    end else begin
      bus.apply = 1'b0; bus.pre_spike = 1'b0; bus.post_spike = 1'b0;
    end
    check("busy_after_apply", bus.busy, upd);
    if (upd) begin
      k = 0;
      do begin
        @(posedge clk); #1; k++;
      end while (!bus.update_valid && k < LAT + 3);
      bus.apply = 1'b0; bus.pre_spike = 1'b0;
      check("update_latency", k, LAT);
      mw = exp_w;
      check("weight_update", $signed(bus.weight), mw);
      @(posedge clk); #1;
      check("update_pulse", bus.update_valid, 0);
    end else begin
      bus.apply = 1'b0; bus.pre_spike = 1'b0;
      check("weight_hold", $signed(bus.weight), mw);
    end
    check("pre_age", bus.pre_age, mpre_age);
    check("post_age", bus.post_age, mpost_age);
    @(negedge clk);
  endtask

  task automatic rand_params();
    if ($urandom_range(0, 7) == 0) begin
      bus.m1 = $urandom; bus.b1 = $urandom; bus.m2 = $urandom; bus.b2 = $urandom;
    end else begin
      bus.m1 = 32'($urandom_range(0, 32'h8000)) - 32'h4000;
      bus.m2 = 32'($urandom_range(0, 32'h8000)) - 32'h4000;
      bus.b1 = 32'($urandom_range(0, 32'h20000)) - 32'h10000;
      bus.b2 = 32'($urandom_range(0, 32'h20000)) - 32'h10000;
    end
    bus.window = 16'($urandom_range(1, 8));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.apply = 1'b0; bus.pre_spike = 1'b0; bus.post_spike = 1'b0; bus.load = 1'b0;
    bus.weight_init = '0; bus.m1 = '0; bus.b1 = '0; bus.m2 = '0; bus.b2 = '0; bus.window = 16'd4;
    rst = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    #2;
    check("rst_weight", $signed(bus.weight), 0);
    check("rst_busy", bus.busy, 0);
    check("rst_update_valid", bus.update_valid, 0);
    check("rst_pre_age", bus.pre_age, 0);
    check("rst_post_age", bus.post_age, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // potentiation: dt=2, dw=0x6000
    bus.m1 = -32'sh1000; bus.b1 = 32'sh8000; bus.m2 = -32'sh1000; bus.b2 = 32'sh4000; bus.window = 16'd4;
    do_load(64'h8000);
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0);
    check("pot_weight", $signed(bus.weight), SOFT ? 64'hB000 : 64'hE000);

    // depression: dt=1, dw=0x3000
    do_load(64'h8000);
    step(1'b0, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0);
    check("dep_weight", $signed(bus.weight), SOFT ? 64'h6800 : 64'h5000);

    // dt=5 falls outside window 4
    do_load(64'h8000);
    step(1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("win_weight", $signed(bus.weight), 64'h8000);
    check("win_post_age", bus.post_age, 0);
    check("win_pre_age", bus.pre_age, 5);

    // clamp at W_MAX
    do_load(64'hF000);
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0);
    check("clamp_weight", $signed(bus.weight), SOFT ? 64'hF600 : 64'h1_0000);

    // age saturation over 70000 spike-free timesteps
    do_load(64'h0);
    bus.apply = 1'b1;
    repeat (70000) @(posedge clk);
    #1 bus.apply = 1'b0;
    mpre_age = 65535; mpost_age = 65535;
    check("sat_pre_age", bus.pre_age, 64'hFFFF);
    check("sat_post_age", bus.post_age, 64'hFFFF);
    @(negedge clk);

    // simultaneous spikes, then an update with apply held during busy
    step(1'b1, 1'b1, 1'b0);
    check("simul_pre_age", bus.pre_age, 0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);

    // reset while the update sits in ADD
    do_load(64'h8000);
    step(1'b1, 1'b0, 1'b0);
    bus.apply = 1'b1; bus.post_spike = 1'b1;
    @(posedge clk); #1;
    bus.apply = 1'b0; bus.post_spike = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    model_reset();
    check("mid_rst_weight", $signed(bus.weight), mw);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_pre_age", bus.pre_age, mpre_age);
    check("mid_rst_post_age", bus.post_age, mpost_age);
    @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 1) begin
      @(posedge clk); #1;
      check("mid_rst_no_update", bus.update_valid, 0);
    end
    @(negedge clk);

    for (int i = 0; i < 300; i++) begin
      if (i == 0 || $urandom_range(0, 19) == 0) begin
        rand_params();
        do_load(longint'($urandom_range(0, 32'h1_0000)));
      end
      step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
